// File: rtl/currctrl_bridge_pkg.sv
// rtl/currctrl_bridge_pkg.sv - register map, FSM states and lane helper for the bridge responder
package currctrl_bridge_pkg;

    localparam logic [4:0] REG_ID            = 5'd0;
    localparam logic [4:0] REG_CTRL          = 5'd1;
    localparam logic [4:0] REG_IRQ_STATUS    = 5'd2;
    localparam logic [4:0] REG_IRQ_MASK      = 5'd3;
    localparam logic [4:0] REG_EVT_SET       = 5'd4;
    localparam logic [4:0] REG_SETPOINT_BASE = 5'd8;
    localparam logic [4:0] REG_STATUS_BASE   = 5'd16;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4D4B_3801;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_RELEASE
    } bridge_state_e;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/currctrl_bridge_irq.sv
// rtl/currctrl_bridge_irq.sv - event status/mask latches with registered irq
module currctrl_bridge_irq #(
    parameter int unsigned NUM_EVT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_EVT-1:0] evt_in,
    input  logic               clr_we,
    input  logic               set_we,
    input  logic               mask_we,
    input  logic [31:0]        wr_data,
    input  logic [31:0]        wr_lanes,
    output logic [NUM_EVT-1:0] status,
    output logic [NUM_EVT-1:0] mask,
    output logic               irq
);

    logic [NUM_EVT-1:0] status_q;
    logic [NUM_EVT-1:0] mask_q;
    logic               irq_q;
    logic [NUM_EVT-1:0] clr_bits;
    logic [NUM_EVT-1:0] set_bits;
    logic               unused_wide_bits;

    // wr_data arrives already lane-masked, so it doubles as the W1C/W1S pattern
    assign clr_bits = clr_we ? wr_data[NUM_EVT-1:0] : '0;
    assign set_bits = set_we ? wr_data[NUM_EVT-1:0] : '0;
    assign unused_wide_bits = ^{wr_data, wr_lanes};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            // OR-ing sets after the clear lets a coincident event win
            status_q <= (status_q & ~clr_bits) | evt_in | set_bits;
            if (mask_we) begin
                mask_q <= (mask_q & ~wr_lanes[NUM_EVT-1:0]) | wr_data[NUM_EVT-1:0];
            end
            irq_q <= |(status_q & mask_q);
        end
    end

    assign status = status_q;
    assign mask   = mask_q;
    assign irq    = irq_q;

endmodule

// File: rtl/currctrl_bridge_responder.sv
// rtl/currctrl_bridge_responder.sv - bridge slave: wait-state FSM, register file and irq
module currctrl_bridge_responder
    import currctrl_bridge_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT,
    parameter int unsigned NUM_EVT     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bus_enable,
    input  logic               rw,
    input  logic [6:0]         address,
    input  logic [3:0]         byte_enable,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               acknowledge,
    output logic               irq,
    input  logic [NUM_EVT-1:0] evt_in,
    input  logic [255:0]       status_in,
    output logic [31:0]        ctrl_out,
    output logic [255:0]       setpoint_out,
    output logic [7:0]         setpoint_strobe
);

    bridge_state_e      state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               rw_q;
    logic [4:0]         idx_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic [31:0]        ctrl_q;
    logic [255:0]       setpoint_q;
    logic [7:0]         strobe_q;
    logic               wr_commit;
    logic [31:0]        wr_lanes;
    logic [31:0]        wr_masked;
    logic [7:0]         word_base;
    logic               is_setpoint;
    logic               is_status;
    logic [NUM_EVT-1:0] evt_status;
    logic [NUM_EVT-1:0] evt_mask;
    logic [31:0]        status_ext;
    logic [31:0]        mask_ext;
    logic [31:0]        rd_word;
    logic               unused_addr_lsbs;

    assign unused_addr_lsbs = ^address[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_enable) begin
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // master withdrawing mid-wait is treated as an abort, never acknowledged
                if (!bus_enable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK:     state_d = ST_RELEASE;
            ST_RELEASE: if (!bus_enable) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rw_q    <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (state_q == ST_IDLE && bus_enable) begin
            rw_q    <= rw;
            idx_q   <= address[6:2];
            be_q    <= byte_enable;
            wdata_q <= write_data;
        end
    end

    assign acknowledge = (state_q == ST_ACK);
    assign wr_commit   = acknowledge && !rw_q;
    assign wr_lanes    = lane_mask(be_q);
    assign wr_masked   = wdata_q & wr_lanes;
    assign word_base   = {idx_q[2:0], 5'b0};
    assign is_setpoint = (idx_q[4:3] == REG_SETPOINT_BASE[4:3]);
    assign is_status   = (idx_q[4:3] == REG_STATUS_BASE[4:3]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= '0;
            setpoint_q <= '0;
            strobe_q   <= '0;
        end else begin
            strobe_q <= '0;
            if (wr_commit && idx_q == REG_CTRL) begin
                ctrl_q <= (ctrl_q & ~wr_lanes) | wr_masked;
            end
            if (wr_commit && is_setpoint) begin
                setpoint_q[word_base +: 32] <= (setpoint_q[word_base +: 32] & ~wr_lanes) | wr_masked;
                strobe_q[idx_q[2:0]]        <= 1'b1;
            end
        end
    end

    currctrl_bridge_irq #(
        .NUM_EVT (NUM_EVT)
    ) u_irq (
        .clk      (clk),
        .reset    (reset),
        .evt_in   (evt_in),
        .clr_we   (wr_commit && idx_q == REG_IRQ_STATUS),
        .set_we   (wr_commit && idx_q == REG_EVT_SET),
        .mask_we  (wr_commit && idx_q == REG_IRQ_MASK),
        .wr_data  (wr_masked),
        .wr_lanes (wr_lanes),
        .status   (evt_status),
        .mask     (evt_mask),
        .irq      (irq)
    );

    always_comb begin
        status_ext                = '0;
        mask_ext                  = '0;
        status_ext[NUM_EVT-1:0]   = evt_status;
        mask_ext[NUM_EVT-1:0]     = evt_mask;
    end

    always_comb begin
        rd_word = '0;
        case (idx_q)
            REG_ID:         rd_word = ID_VALUE;
            REG_CTRL:       rd_word = ctrl_q;
            REG_IRQ_STATUS: rd_word = status_ext;
            REG_IRQ_MASK:   rd_word = mask_ext;
            default: begin
                if (is_setpoint) begin
                    rd_word = setpoint_q[word_base +: 32];
                end else if (is_status) begin
                    rd_word = status_in[word_base +: 32];
                end
            end
        endcase
    end

    assign read_data       = acknowledge ? rd_word : '0;
    assign ctrl_out        = ctrl_q;
    assign setpoint_out    = setpoint_q;
    assign setpoint_strobe = strobe_q;

endmodule

// File: tb/tb_currctrl_bridge_responder.sv
// tb/tb_currctrl_bridge_responder.sv - randomized self-checking bench against a register-level model
module tb_currctrl_bridge_responder;

    localparam int          WS = 3;
    localparam int          NE = 8;
    localparam logic [31:0] ID = 32'h4D4B_3801;

    logic          clk = 1'b0;
    logic          reset;
    logic          bus_enable;
    logic          rw;
    logic [6:0]    address;
    logic [3:0]    byte_enable;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          acknowledge;
    logic          irq;
    logic [NE-1:0] evt_in;
    logic [255:0]  status_in;
    logic [31:0]   ctrl_out;
    logic [255:0]  setpoint_out;
    logic [7:0]    setpoint_strobe;

    always #5 clk = ~clk;

    currctrl_bridge_responder #(
        .WAIT_STATES (WS),
        .ID_VALUE    (ID),
        .NUM_EVT     (NE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .bus_enable      (bus_enable),
        .rw              (rw),
        .address         (address),
        .byte_enable     (byte_enable),
        .write_data      (write_data),
        .read_data       (read_data),
        .acknowledge     (acknowledge),
        .irq             (irq),
        .evt_in          (evt_in),
        .status_in       (status_in),
        .ctrl_out        (ctrl_out),
        .setpoint_out    (setpoint_out),
        .setpoint_strobe (setpoint_strobe)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    int            rd_leak;
    logic [31:0]   m_ctrl;
    logic [NE-1:0] m_status;
    logic [NE-1:0] m_mask;
    logic          m_irq;
    logic [31:0]   m_sp [8];
    logic [7:0]    m_strobe;
    bit            evt_rand;
    bit            pend_we;
    logic [4:0]    pend_idx;
    logic [31:0]   pend_data;
    logic [3:0]    pend_be;
    logic [31:0]   rd;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) begin
            if (be[l]) r[8*l +: 8] = wd[8*l +: 8];
        end
        return r;
    endfunction

    function automatic logic [255:0] sp_packed();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = m_sp[k];
        return v;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        int k;
        k = int'(idx);
        if (k == 0) return ID;
        if (k == 1) return m_ctrl;
        if (k == 2) return 32'(m_status);
        if (k == 3) return 32'(m_mask);
        if (k >= 8 && k <= 15) return m_sp[k-8];
        if (k >= 16 && k <= 23) return status_in[32*(k-16) +: 32];
        return '0;
    endfunction

    task automatic model_reset();
        m_ctrl   = '0;
        m_status = '0;
        m_mask   = '0;
        m_irq    = 1'b0;
        m_strobe = '0;
        for (int k = 0; k < 8; k++) m_sp[k] = '0;
    endtask

    // one clock: advance the model on the rising edge, compare on the falling edge
    task automatic tick();
        logic [31:0] wm;
        logic        nxt_irq;
        int          k;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            nxt_irq  = |(m_status & m_mask);
            wm       = merge(32'h0, pend_data, pend_be);
            k        = int'(pend_idx);
            m_strobe = '0;
            m_status = (m_status & ~((pend_we && k == 2) ? wm[NE-1:0] : '0))
                     | evt_in | ((pend_we && k == 4) ? wm[NE-1:0] : '0);
            if (pend_we && k == 1) m_ctrl = merge(m_ctrl, pend_data, pend_be);
            if (pend_we && k == 3) m_mask = NE'(merge(32'(m_mask), pend_data, pend_be));
            if (pend_we && k >= 8 && k <= 15) begin
                m_sp[k-8]     = merge(m_sp[k-8], pend_data, pend_be);
                m_strobe[k-8] = 1'b1;
            end
            m_irq = nxt_irq;
        end
        pend_we = 1'b0;
        @(negedge clk);
        check("irq", irq, m_irq);
        check("setpoint_strobe", setpoint_strobe, m_strobe);
        check("ctrl_out", ctrl_out, m_ctrl);
        check("setpoint_out", setpoint_out, sp_packed());
        if (!acknowledge && read_data != 0) rd_leak++;
        evt_in = (evt_rand && $urandom_range(0, 3) == 0) ? NE'($urandom) : '0;
    endtask

    task automatic bus_cycle(input logic is_rd, input logic [6:0] addr, input logic [3:0] be,
                             input logic [31:0] wd, input int hold, input logic [NE-1:0] evt_commit,
                             output logic [31:0] rdata);
        int          acks;
        int          lat;
        logic [31:0] exp_rd;
        acks   = 0;
        lat    = -1;
        exp_rd = '0;
        rdata  = '0;
        bus_enable = 1'b1; rw = is_rd; address = addr; byte_enable = be; write_data = wd;
        for (int n = 1; n <= WS + 2 + hold; n++) begin
            if (n == WS + 2) begin
                pend_we = !is_rd; pend_idx = addr[6:2]; pend_data = wd; pend_be = be;
                evt_in  = evt_in | evt_commit;
            end
            tick();
            if (n == WS + 1) exp_rd = model_read(addr[6:2]);
            if (acknowledge) begin
                acks++;
                if (lat < 0) begin
                    lat   = n;
                    rdata = read_data;
                end
            end
        end
        bus_enable = 1'b0;
        write_data = $urandom;
        tick();
        if (acknowledge) acks++;
        check("ack_latency", lat, WS + 1);
        check("ack_count", acks, 1);
        if (is_rd) check("read_data", rdata, exp_rd);
    endtask

    task automatic aborted_write(input logic [6:0] addr, input logic [31:0] wd, input int drop_after, input bit use_reset);
        int acks;
        acks = 0;
        bus_enable = 1'b1; rw = 1'b0; address = addr; byte_enable = 4'hF; write_data = wd;
        for (int n = 1; n <= drop_after; n++) begin
            tick();
            if (acknowledge) acks++;
        end
        bus_enable = 1'b0;
        if (use_reset) reset = 1'b1;
        for (int n = 0; n < WS + 3; n++) begin
            tick();
            if (acknowledge) acks++;
            if (n == 0) reset = 1'b0;
        end
        if (use_reset) check("reset_abort_acks", acks, 0);
        else           check("drop_abort_acks", acks, 0);
    endtask

    initial begin
        reset = 1'b1; bus_enable = 1'b0; rw = 1'b0; address = '0; byte_enable = '0;
        write_data = '0; evt_in = '0; status_in = '0; evt_rand = 1'b0;
        pend_we = 1'b0; pend_idx = '0; pend_data = '0; pend_be = '0; rd_leak = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ack", acknowledge, 1'b0);
        check("rst_read_data", read_data, 32'h0);
        check("rst_irq", irq, 1'b0);
        check("rst_ctrl", ctrl_out, 32'h0);
        check("rst_setpoint", setpoint_out, 256'h0);
        check("rst_strobe", setpoint_strobe, 8'h0);
        reset = 1'b0;

        bus_cycle(1'b1, 7'h00, 4'hF, 32'h0, 4, '0, rd);
        check("id_value", rd, 32'h4D4B_3801);

        bus_cycle(1'b0, 7'h20, 4'b0101, 32'hDEADBEEF, 0, '0, rd);
        bus_cycle(1'b1, 7'h20, 4'hF, 32'h0, 0, '0, rd);
        check("sp0_lanes", rd, 32'h00AD00EF);

        bus_cycle(1'b0, 7'h08, 4'hF, 32'hFFFF_FFFF, 0, '0, rd);
        bus_cycle(1'b0, 7'h0C, 4'hF, 32'h1, 0, '0, rd);
        evt_in = NE'(1);
        tick();
        tick();
        check("irq_after_evt", irq, 1'b1);
        bus_cycle(1'b0, 7'h08, 4'hF, 32'h1, 0, '0, rd);
        check("irq_after_w1c", irq, 1'b0);
        evt_in = NE'(1);
        tick();
        tick();
        bus_cycle(1'b0, 7'h08, 4'hF, 32'h1, 0, NE'(1), rd);
        check("irq_set_wins", irq, 1'b1);
        bus_cycle(1'b1, 7'h08, 4'hF, 32'h0, 0, '0, rd);
        check("status_set_wins", rd, 32'h1);

        bus_cycle(1'b1, 7'h7C, 4'hF, 32'h0, 1, '0, rd);
        check("unmapped_read", rd, 32'h0);
        bus_cycle(1'b0, 7'h18, 4'hF, 32'hFFFF_FFFF, 0, '0, rd);
        bus_cycle(1'b1, 7'h18, 4'hF, 32'h0, 0, '0, rd);
        check("unmapped_write", rd, 32'h0);

        status_in[96 +: 32] = 32'h12345678;
        bus_cycle(1'b1, 7'h4C, 4'hF, 32'h0, 0, '0, rd);
        check("status_word3", rd, 32'h12345678);

        bus_cycle(1'b0, 7'h04, 4'hF, 32'h1111_1111, 0, '0, rd);
        aborted_write(7'h04, 32'hFFFF_FFFF, 2, 1'b0);
        bus_cycle(1'b1, 7'h04, 4'hF, 32'h0, 0, '0, rd);
        check("ctrl_after_drop", rd, 32'h1111_1111);
        aborted_write(7'h24, 32'hA5A5_A5A5, 2, 1'b1);
        bus_cycle(1'b1, 7'h04, 4'hF, 32'h0, 0, '0, rd);
        check("ctrl_after_reset", rd, 32'h0);
        bus_cycle(1'b1, 7'h24, 4'hF, 32'h0, 0, '0, rd);
        check("sp1_after_reset", rd, 32'h0);
        bus_cycle(1'b1, 7'h00, 4'hF, 32'h0, 0, '0, rd);
        check("id_after_reset", rd, 32'h4D4B_3801);

        evt_rand = 1'b1;
        for (int i = 0; i < 80; i++) begin
            for (int k = 0; k < 8; k++) status_in[32*k +: 32] = $urandom;
            bus_cycle(1'($urandom_range(0, 1)), 7'($urandom), 4'($urandom), $urandom,
                      int'($urandom_range(0, 3)), '0, rd);
        end
        evt_rand = 1'b0;
        tick();

        check("read_data_idle_zero", rd_leak, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
